// File: rtl/serial_sample_fifo.sv
// Serial sample receiver for a Raspberry Pi shift link, feeding a frame FIFO.
// Frames of CHANNELS samples are popped on rising edges of the ready pin.
module serial_sample_fifo #(
    parameter int SAMPLE_W  = 16,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 64,
    parameter int LOW_WATER = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rpi_clk,
    input  logic                         serial,
    input  logic                         ready,
    output logic [SAMPLE_W*CHANNELS-1:0] data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         rpi_interrupt,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = SAMPLE_W * CHANNELS;
    localparam int BW = $clog2(SAMPLE_W);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [2:0]          clk_s;
    logic [2:0]          rdy_s;
    logic [1:0]          ser_s;
    logic                clk_rise;
    logic                rdy_rise;
    logic                ser_bit;

    logic [SAMPLE_W-1:0] sr;
    logic [SAMPLE_W-1:0] sample_next;
    logic [BW-1:0]       bit_cnt;
    logic [CW-1:0]       ch;
    logic [FW-1:0]       stage;
    logic                push_pend;

    logic [FW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                pop;
    logic                push_ok;

    // Third flop of each chain only serves edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s <= '0;
            rdy_s <= '0;
            ser_s <= '0;
        end else begin
            clk_s <= {clk_s[1:0], rpi_clk};
            rdy_s <= {rdy_s[1:0], ready};
            ser_s <= {ser_s[0], serial};
        end
    end

    assign clk_rise = clk_s[1] & ~clk_s[2];
    assign rdy_rise = rdy_s[1] & ~rdy_s[2];
    assign ser_bit  = ser_s[1];

    always_comb begin
        sample_next = {ser_bit, sr[SAMPLE_W-1:1]};
        if (MSB_FIRST)
            sample_next = {sr[SAMPLE_W-2:0], ser_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            bit_cnt   <= '0;
            ch        <= '0;
            stage     <= '0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            if (clk_rise) begin
                sr <= sample_next;
                if (bit_cnt == BW'(SAMPLE_W - 1)) begin
                    bit_cnt <= '0;
                    stage[int'(ch)*SAMPLE_W +: SAMPLE_W] <= sample_next;
                    if (ch == CW'(CHANNELS - 1)) begin
                        ch        <= '0;
                        push_pend <= 1'b1;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // A full FIFO still takes a push when a pop frees the head slot.
    assign pop     = rdy_rise && (level != '0);
    assign push_ok = push_pend && ((level != LW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= stage;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data          <= '0;
            level         <= '0;
            wptr          <= '0;
            rptr          <= '0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            rpi_interrupt <= 1'b1;
        end else begin
            overrun       <= push_pend && !push_ok;
            underrun      <= rdy_rise && (level == '0);
            rpi_interrupt <= (level < LW'(LOW_WATER));
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop) begin
                data <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !push_ok)
                level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_sample_fifo.sv
// Scoreboard bench for serial_sample_fifo: default instance plus an
// 8-bit MSB-first mono instance.
module tb_serial_sample_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rpi_clk = 1'b0;
    logic        serial = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data;
    logic [6:0]  level;
    logic        rpi_interrupt;
    logic        overrun;
    logic        underrun;

    logic        rpi_clk2 = 1'b0;
    logic        serial2 = 1'b0;
    logic        ready2 = 1'b0;
    logic [7:0]  data2;
    logic [2:0]  level2;
    logic        irq2;
    logic        ovr2;
    logic        und2;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    int und_cnt = 0;
    int exp_ovr = 0;
    int exp_und = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mq [$];
    logic [31:0] last_pop = 32'h0;
    event        pop_ev;

    always #5 clk = ~clk;

    serial_sample_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .rpi_clk       (rpi_clk),
        .serial        (serial),
        .ready         (ready),
        .data          (data),
        .level         (level),
        .rpi_interrupt (rpi_interrupt),
        .overrun       (overrun),
        .underrun      (underrun)
    );

    serial_sample_fifo #(
        .SAMPLE_W  (8),
        .CHANNELS  (1),
        .DEPTH     (4),
        .LOW_WATER (2),
        .MSB_FIRST (1'b1)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .rpi_clk       (rpi_clk2),
        .serial        (serial2),
        .ready         (ready2),
        .data          (data2),
        .level         (level2),
        .rpi_interrupt (irq2),
        .overrun       (ovr2),
        .underrun      (und2)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (overrun)
            ovr_cnt++;
        if (underrun)
            und_cnt++;
    end

    // Monitor: each completed pop is checked against the scoreboard head.
    always begin
        @(pop_ev);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_data: got %0h want <no entry>", data);
        end else begin
            chk("pop_data", data, exp_q.pop_front());
        end
    end

    task automatic model_push(input logic [31:0] f);
        if (mq.size() < 64)
            mq.push_back(f);
        else
            exp_ovr++;
    endtask

    task automatic model_pop();
        logic [31:0] e;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            last_pop = e;
        end else begin
            e = last_pop;
            exp_und++;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input bit sel, input logic b);
        @(negedge clk);
        if (sel) serial2 = b; else serial = b;
        repeat (3) @(negedge clk);
        if (sel) rpi_clk2 = 1'b1; else rpi_clk = 1'b1;
        repeat (3) @(negedge clk);
        if (sel) rpi_clk2 = 1'b0; else rpi_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 0; i < 32; i++)
            send_bit(1'b0, f[i]);
        repeat (4) @(negedge clk);
        model_push(f);
    endtask

    task automatic do_pop();
        model_pop();
        @(negedge clk);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        ->pop_ev;
        repeat (2) @(negedge clk);
    endtask

    // Last rpi_clk rise leads the ready rise by one clk so push and pop coincide.
    task automatic aligned_frame(input logic [31:0] f);
        for (int i = 0; i < 31; i++)
            send_bit(1'b0, f[i]);
        @(negedge clk);
        serial = f[31];
        repeat (3) @(negedge clk);
        rpi_clk = 1'b1;
        @(negedge clk);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        rpi_clk = 1'b0;
        ready = 1'b0;
        model_pop();
        model_push(f);
        repeat (6) @(negedge clk);
        ->pop_ev;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        last_pop = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_data", data, 0);
        chk("rst_irq", rpi_interrupt, 1);
        chk("rst_ovr", overrun, 0);
        chk("rst_und", underrun, 0);

        send_frame(32'hABCD_1234);
        chk("one_level", level, 1);
        chk("one_irq", rpi_interrupt, 1);
        do_pop();
        chk("one_level_pop", level, 0);
        chk("one_irq_pop", rpi_interrupt, 1);

        do_pop();
        chk("und_count", und_cnt, exp_und);
        chk("und_level", level, 0);

        for (int i = 0; i < 64; i++) begin
            send_frame(32'hC0DE_0000 | i);
            if (i == 30) begin
                chk("fill31_level", level, 31);
                chk("fill31_irq", rpi_interrupt, 1);
            end
            if (i == 31) begin
                chk("fill32_level", level, 32);
                chk("fill32_irq", rpi_interrupt, 0);
            end
        end
        chk("full_level", level, 64);
        chk("full_irq", rpi_interrupt, 0);
        chk("full_ovr_none", ovr_cnt, 0);

        send_frame(32'hDEAD_BEEF);
        chk("ovr_count", ovr_cnt, exp_ovr);
        chk("ovr_level", level, 64);

        aligned_frame(32'h5A5A_0F0F);
        chk("align_ovr", ovr_cnt, exp_ovr);
        chk("align_level", level, 64);

        do_pop();
        do_pop();
        chk("drain_level", level, 62);

        for (int i = 0; i < 20; i++)
            send_bit(1'b0, 1'b1);
        do_reset();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_irq", rpi_interrupt, 1);
        send_frame(32'h0000_0001);
        chk("post_rst_level", level, 1);
        do_pop();
        chk("post_rst_pop_level", level, 0);
        chk("und_total", und_cnt, exp_und);

        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("msb_level", level2, 1);
        @(negedge clk);
        ready2 = 1'b1;
        repeat (3) @(negedge clk);
        ready2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("msb_data", data2, 8'h81);
        chk("msb_level_pop", level2, 0);
        chk("msb_ovr", ovr2, 0);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sample_fifo.md
SERIAL_SAMPLE_FIFO -- requirements
Module: serial_sample_fifo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, bits per sample.
REQ-002 SHALL have parameter CHANNELS, default 2, samples per frame (1..4).
REQ-003 SHALL have parameter DEPTH, default 64, frames stored; power of two, at least 4.
REQ-004 SHALL have parameter LOW_WATER, default 32, refill-request threshold in frames.
REQ-005 SHALL have parameter MSB_FIRST, default 0; 0 means serial bit 0 arrives first.
REQ-006 SHALL have port clk, input, 1, main clock; all logic runs on rising clk, giving one clock domain.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rpi_clk, input, 1, asynchronous shift clock from the Pi, sampled as data.
REQ-009 SHALL have port serial, input, 1, serial data from the Pi.
REQ-010 SHALL have port ready, input, 1, asynchronous; a rising edge requests the next frame.
REQ-011 SHALL have port data, output, SAMPLE_W*CHANNELS, current frame; channel 0 in the LSBs.
REQ-012 SHALL have port level, output, log2(DEPTH)+1, frames stored.
REQ-013 SHALL have port rpi_interrupt, output, 1, high while more data is wanted.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a complete frame is dropped.
REQ-015 SHALL have port underrun, output, 1, one-cycle pulse when a pop is requested while empty.

Function
REQ-016 SHALL pass rpi_clk, serial and ready each through a 2-flop synchronizer; edges are detected on a third flop, so latency is 3 clk from pin to event.
REQ-017 SHALL shift one synchronized serial bit per detected rpi_clk rise into a SAMPLE_W shift register, in the order set by MSB_FIRST.
REQ-018 SHALL, on the SAMPLE_W-th bit, write the sample into channel slot ch of a staging frame, clear the bit counter and advance ch.
REQ-019 SHALL, when slot CHANNELS-1 completes, push the staging frame on the next clk and reset ch to 0.
REQ-020 SHALL accept the push if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
REQ-021 SHALL otherwise drop the frame, pulse overrun and leave level and memory unchanged.
REQ-022 SHALL, on a detected ready rise with level>0, load data with the oldest frame one clk later and decrement level.
REQ-023 SHALL, on a detected ready rise with level==0, hold data and pulse underrun.
REQ-024 SHALL leave level unchanged when an accepted push and a pop occur in the same cycle; the pop returns the pre-existing head.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; level disambiguates full from empty.
REQ-026 SHALL register rpi_interrupt = (level < LOW_WATER), updated one clk after level changes.
REQ-027 SHALL treat rpi_clk edges closer than 3 clk apart as outside spec; behaviour is undefined.

Reset
REQ-028 SHALL, on rst high at a clk edge, clear data, level, pointers, bit counter, ch, shift register, overrun, underrun and the synchronizer flops; rpi_interrupt SHALL be 1 from the next cycle.
REQ-029 SHALL discard any partially received sample or frame on reset mid-transfer; after reset, the first bit starts channel 0, bit 0.
REQ-030 SHALL ignore edges on rpi_clk and ready while rst is high, and SHALL NOT detect a spurious edge on the cycle rst deasserts.

Verification
REQ-031 Defaults: shift 32 bits encoding L=0x1234, R=0xABCD, then pulse ready -> level goes 1 then 0, data=0xABCD1234, rpi_interrupt stays 1.
REQ-032 Fill 64 frames with no reads -> level=64, rpi_interrupt=0 from frame 32; a 65th frame pulses overrun once and level stays 64.
REQ-033 Pulse ready when level=0 -> underrun pulses for 1 cycle and data keeps its previous value.
REQ-034 At level=64, align a final push with a ready rise -> no overrun, level stays 64, data = oldest frame.
REQ-035 Assert rst after 20 of 32 bits, then send a full frame 0x00000001 -> level=1; popped data=0x00000001.
REQ-036 MSB_FIRST=1, SAMPLE_W=8, CHANNELS=1: shift bits 1,0,0,0,0,0,0,1, then pop -> data=0x81.
